fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the transmit-side asynchronous FIFO between several requesters in the `w_clk` domain, such as a command processor, a status reporter and a loopback path. It grants one requester at a time for a bounded burst or a whole message. It forwards accepted beats as `fifo_w_en`/`fifo_w_data`, and it applies FIFO-full backpressure to the granted requester only.

---
 rtl/fifo_wr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 563 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// ----------------
// Round-robin arbiter that shares the single write port of the transmit-side
// asynchronous FIFO between NUM_REQ requesters in the w_clk domain. One
// requester is granted at a time. A grant lasts for a bounded burst of up to
// MAX_BURST beats, or until the requester's end-of-message beat. FIFO-full
// backpressure is applied to the granted requester only.
//
// Optional feature (compile-time macro):
//   ARB_PKT_LOCK_EN - packet lock. A grant ends only on an accepted beat with
//                     req_last. MAX_BURST is ignored, and a low req_valid
//                     does not release the grant. Whole messages are
//                     therefore never interleaved in the FIFO.
//
// Parameters:
//   NUM_REQ     number of requesters (2..16)
//   DATA_WIDTH  beat width, equal to the FIFO data width
//   MAX_BURST   maximum beats per grant (1..255)
//
// Ports:
//   w_clk        write-domain clock, rising edge
//   w_rst_n      asynchronous active-low reset
//   req_valid    per-requester beat valid
//   req_last     per-requester end-of-message flag, qualified by req_valid
//   req_data     requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    per-requester accept, at most one bit high
//   fifo_w_en    FIFO write strobe
//   fifo_w_data  FIFO write data
//   fifo_w_full  FIFO full flag
//   grant_id     index of the current or most recent grant (registered)
//   busy         high while a grant is active (registered)

module fifo_wr_arbiter #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 8,
   parameter  int MAX_BURST  = 4,
   localparam int GID_W      = $clog2(NUM_REQ)
) (
   input  logic                          w_clk,
   input  logic                          w_rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_w_data,
   input  logic                          fifo_w_full,
   output logic [GID_W-1:0]              grant_id,
   output logic                          busy
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   state_t                state_q, state_d;
   logic [GID_W-1:0]      grant_id_q, grant_id_d;
   logic [GID_W-1:0]      last_grant_q, last_grant_d;
   logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic                  busy_q, busy_d;

   logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
   logic                  found;
   logic [GID_W-1:0]      pick_idx;
   logic [GID_W-1:0]      cand_idx;
   logic                  grant_valid;
   logic                  grant_last;
   logic                  accept;
   logic                  burst_done;
   logic                  release_grant;

   // Split the flat data bus into one word per requester.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Round-robin search: first requesting index starting just above the
   // previous grant and wrapping. Because last_grant resets to NUM_REQ-1,
   // the first grant after reset goes to the lowest requesting index.
   always_comb begin
      found    = 1'b0;
      pick_idx = '0;
      cand_idx = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand_idx = GID_W'((int'(last_grant_q) + i) % NUM_REQ);
         if (!found && req_valid[cand_idx]) begin
            found    = 1'b1;
            pick_idx = cand_idx;
         end
      end
   end

   // Write-port steering. These outputs are combinational so that a full
   // flag rising mid-burst blocks the strobe in the same cycle.
   always_comb begin
      grant_valid = req_valid[grant_id_q];
      grant_last  = req_last[grant_id_q];
      fifo_w_data = req_data_arr[grant_id_q];
      req_ready   = '0;
      if (state_q == ST_GRANT && !fifo_w_full) begin
         req_ready[grant_id_q] = 1'b1;
      end
      accept    = (state_q == ST_GRANT) && grant_valid && !fifo_w_full;
      fifo_w_en = accept;
   end

`ifdef ARB_PKT_LOCK_EN
   // Packet lock: only an accepted last beat ends the grant.
   assign burst_done    = 1'b0;
   assign release_grant = 1'b0;
`else
   // The beat being accepted now is the MAX_BURST-th one when the count
   // still sits one below the limit. A low valid releases the grant only
   // while the FIFO has space, so a requester is never dropped because of
   // backpressure.
   assign burst_done    = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
   assign release_grant = !grant_valid && !fifo_w_full;
`endif

   // Next-state logic. A last beat that also completes the burst simply
   // exits once, since both conditions feed the same transition.
   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d      = ST_GRANT;
               grant_id_d   = pick_idx;
               last_grant_d = pick_idx;
               beat_cnt_d   = '0;
            end
         end
         ST_GRANT: begin
            if (accept) begin
               if (beat_cnt_q != CNT_W'(MAX_BURST)) begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
               if (grant_last || burst_done) begin
                  state_d = ST_IDLE;
               end
            end else if (release_grant) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_GRANT);
   end

   // State registers. Reset is asynchronous, so an in-flight burst stops
   // strobing the FIFO the moment w_rst_n falls.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q      <= ST_IDLE;
         grant_id_q   <= '0;
         last_grant_q <= GID_W'(NUM_REQ - 1);
         beat_cnt_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         busy_q       <= busy_d;
      end
   end

   assign grant_id = grant_id_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// -------------------
// Self-checking bench for fifo_wr_arbiter. Each requester is a queue of
// beats that it presents and holds until accepted. A grant-level reference
// model (owner index, beats taken, previous owner) predicts busy, grant_id,
// req_ready and fifo_w_en every cycle. Directed scenarios also compare the
// observed FIFO write log against fixed expected sequences.

module tb_fifo_wr_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 8;
   localparam int MAX_BURST  = 4;
   localparam int GID_W      = 2;

   logic                          w_clk;
   logic                          w_rst_n;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_w_en;
   logic [DATA_WIDTH-1:0]         fifo_w_data;
   logic                          fifo_w_full;
   logic [GID_W-1:0]              grant_id;
   logic                          busy;

   fifo_wr_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_BURST  (MAX_BURST)
   ) dut (
      .w_clk       (w_clk),
      .w_rst_n     (w_rst_n),
      .req_valid   (req_valid),
      .req_last    (req_last),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .fifo_w_en   (fifo_w_en),
      .fifo_w_data (fifo_w_data),
      .fifo_w_full (fifo_w_full),
      .grant_id    (grant_id),
      .busy        (busy)
   );

   // Requester queues and drive controls
   logic [7:0] q_data [NUM_REQ][$];
   bit         q_last [NUM_REQ][$];
   int         gap [NUM_REQ];
   logic       full_drv;

   // Reference model: owner = -1 means no grant is active
   int m_owner;
   int m_cnt;
   int m_lastg;
   int m_gid;

   // Observed FIFO write log
   int         wr_gid [$];
   logic [7:0] wr_data [$];
   int         wr_cyc [$];

   int cyc;
   int checks;
   int failures;

   logic               obs_busy;
   logic               obs_en;
   logic [NUM_REQ-1:0] obs_ready;
   logic [GID_W-1:0]   obs_gid;

   initial begin
      w_clk = 1'b0;
      forever #5 w_clk = ~w_clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic model_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_lastg = NUM_REQ - 1;
      m_gid   = 0;
   endtask

   task automatic clear_log();
      wr_gid.delete();
      wr_data.delete();
      wr_cyc.delete();
   endtask

   task automatic clear_queues();
      for (int i = 0; i < NUM_REQ; i++) begin
         q_data[i].delete();
         q_last[i].delete();
         gap[i] = 0;
      end
   endtask

   task automatic push_msg(input int r, input int n, input logic [7:0] base, input bit with_last);
      for (int k = 0; k < n; k++) begin
         q_data[r].push_back(base + 8'(k));
         q_last[r].push_back(with_last && (k == n - 1));
      end
   endtask

   function automatic bit queues_empty();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (q_data[i].size() > 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic drive_inputs();
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (q_data[i].size() > 0 && gap[i] == 0) begin
            req_valid[i] = 1'b1;
            req_last[i]  = q_last[i][0];
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = q_data[i][0];
         end
      end
      fifo_w_full = full_drv;
   endtask

   task automatic do_reset();
      w_rst_n  = 1'b0;
      full_drv = 1'b0;
      clear_queues();
      drive_inputs();
      repeat (2) @(posedge w_clk);
      #1;
      cyc++;
      w_rst_n = 1'b1;
      model_reset();
      clear_log();
   endtask

   // One clock cycle: drive, sample mid-cycle against the model, advance
   // the model, then pop beats the requesters saw accepted.
   task automatic step();
      logic [NUM_REQ-1:0] exp_ready;
      logic [NUM_REQ-1:0] hs;
      logic               exp_busy;
      logic               exp_en;
      logic               acc;
      logic               done;
      logic [GID_W-1:0]   exp_gid;
      logic [GID_W-1:0]   gi;
      logic [7:0]         exp_data;
      int                 idx;
      drive_inputs();
      #4;
      exp_busy  = (m_owner >= 0);
      exp_gid   = m_gid[GID_W-1:0];
      exp_ready = '0;
      exp_en    = 1'b0;
      exp_data  = '0;
      acc       = 1'b0;
      gi        = '0;
      if (m_owner >= 0) begin
         gi = m_owner[GID_W-1:0];
         if (!fifo_w_full) exp_ready[gi] = 1'b1;
         acc    = req_valid[gi] && !fifo_w_full;
         exp_en = acc;
         if (acc) exp_data = q_data[gi][0];
      end
      obs_busy  = busy;
      obs_en    = fifo_w_en;
      obs_ready = req_ready;
      obs_gid   = grant_id;
      checks += 4;
      if (obs_busy !== exp_busy) begin
         failures++;
         $display("[TB] FAIL busy cyc=%0d got=%0b exp=%0b", cyc, obs_busy, exp_busy);
      end
      if (obs_gid !== exp_gid) begin
         failures++;
         $display("[TB] FAIL grant_id cyc=%0d got=%0d exp=%0d", cyc, obs_gid, exp_gid);
      end
      if (obs_ready !== exp_ready) begin
         failures++;
         $display("[TB] FAIL req_ready cyc=%0d got=%b exp=%b", cyc, obs_ready, exp_ready);
      end
      if (obs_en !== exp_en) begin
         failures++;
         $display("[TB] FAIL fifo_w_en cyc=%0d got=%0b exp=%0b", cyc, obs_en, exp_en);
      end
      if (exp_en && obs_en) begin
         checks++;
         if (fifo_w_data !== exp_data) begin
            failures++;
            $display("[TB] FAIL fifo_w_data cyc=%0d got=%02h exp=%02h", cyc, fifo_w_data, exp_data);
         end
      end
      if (obs_en === 1'b1) begin
         wr_gid.push_back(int'(grant_id));
         wr_data.push_back(fifo_w_data);
         wr_cyc.push_back(cyc);
      end
      if (m_owner < 0) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (m_lastg + k) % NUM_REQ;
            if (m_owner < 0 && req_valid[idx[GID_W-1:0]]) m_owner = idx;
         end
         if (m_owner >= 0) begin
            m_gid   = m_owner;
            m_lastg = m_owner;
            m_cnt   = 0;
         end
      end else begin
         done = 1'b0;
         if (acc) begin
            m_cnt++;
            done = req_last[gi];
`ifndef ARB_PKT_LOCK_EN
            if (m_cnt >= MAX_BURST) done = 1'b1;
`endif
         end
`ifndef ARB_PKT_LOCK_EN
         else if (!req_valid[gi] && !fifo_w_full) done = 1'b1;
`endif
         if (done) m_owner = -1;
      end
      hs = req_valid & req_ready;
      @(posedge w_clk);
      #1;
      cyc++;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (hs[i] && q_data[i].size() > 0) begin
            void'(q_data[i].pop_front());
            void'(q_last[i].pop_front());
         end
         if (gap[i] > 0) gap[i]--;
      end
   endtask

   task automatic run_until_drained(input int budget, input string name);
      int n;
      n = 0;
      while ((!queues_empty() || m_owner >= 0) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (!queues_empty() || m_owner >= 0) begin
         failures++;
         $display("[TB] FAIL %s_drain cycles=%0d got=pending exp=drained", name, n);
      end
   endtask

   task automatic test_reset();
      w_rst_n  = 1'b0;
      full_drv = 1'b0;
      clear_queues();
      push_msg(3, 2, 8'h30, 1'b1);
      drive_inputs();
      repeat (2) @(posedge w_clk);
      #1;
      cyc++;
      checks += 4;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_busy got=%0b exp=0", busy);
      end
      if (grant_id !== 2'd0) begin
         failures++;
         $display("[TB] FAIL reset_grant_id got=%0d exp=0", grant_id);
      end
      if (req_ready !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_req_ready got=%b exp=0000", req_ready);
      end
      if (fifo_w_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_fifo_w_en got=%0b exp=0", fifo_w_en);
      end
      w_rst_n = 1'b1;
      model_reset();
      clear_log();
      run_until_drained(20, "reset");
      checks++;
      if (wr_gid.size() != 2 || wr_gid[0] != 3) begin
         failures++;
         $display("[TB] FAIL reset_first_grant got_writes=%0d exp_writes=2 exp_gid=3", wr_gid.size());
      end
   endtask

   task automatic test_single();
      int c0;
      do_reset();
      c0 = cyc;
      push_msg(2, 3, 8'hA1, 1'b1);
      run_until_drained(20, "single");
      checks++;
      if (wr_data.size() != 3) begin
         failures++;
         $display("[TB] FAIL single_count got=%0d exp=3", wr_data.size());
      end
      for (int k = 0; k < 3; k++) begin
         if (k < wr_data.size()) begin
            checks++;
            if (wr_gid[k] != 2 || wr_data[k] !== 8'hA1 + 8'(k) || wr_cyc[k] != c0 + 1 + k) begin
               failures++;
               $display("[TB] FAIL single_beat%0d got=gid%0d/%02h@%0d exp=gid2/%02h@%0d",
                        k, wr_gid[k], wr_data[k], wr_cyc[k], 8'hA1 + 8'(k), c0 + 1 + k);
            end
         end
      end
      step();
      checks++;
      if (obs_busy !== 1'b0 || obs_gid !== 2'd2) begin
         failures++;
         $display("[TB] FAIL single_idle got=busy%0b/gid%0d exp=busy0/gid2", obs_busy, obs_gid);
      end
   endtask

`ifndef ARB_PKT_LOCK_EN
   task automatic test_round_robin();
      int c0;
      int n;
      int beat;
      int exp_gid;
      int exp_cyc;
      logic [7:0] exp_d;
      do_reset();
      c0 = cyc;
      for (int i = 0; i < NUM_REQ; i++) push_msg(i, 8, 8'(i * 16), 1'b0);
      run_until_drained(80, "rr");
      checks++;
      if (wr_data.size() != 32) begin
         failures++;
         $display("[TB] FAIL rr_count got=%0d exp=32", wr_data.size());
      end
      for (int k = 0; k < 32; k++) begin
         if (k < wr_data.size()) begin
            n       = k / 4;
            exp_gid = n % 4;
            beat    = (n / 4) * 4 + k % 4;
            exp_d   = 8'(exp_gid * 16 + beat);
            exp_cyc = c0 + 1 + k + k / 4;
            checks++;
            if (wr_gid[k] != exp_gid || wr_data[k] !== exp_d || wr_cyc[k] != exp_cyc) begin
               failures++;
               $display("[TB] FAIL rr_beat%0d got=gid%0d/%02h@%0d exp=gid%0d/%02h@%0d",
                        k, wr_gid[k], wr_data[k], wr_cyc[k], exp_gid, exp_d, exp_cyc);
            end
         end
      end
   endtask
`endif

   task automatic test_backpressure();
      int n;
      do_reset();
      push_msg(1, 4, 8'hB0, 1'b1);
      n = 0;
      while (wr_data.size() < 2 && n < 10) begin
         step();
         n++;
      end
      full_drv = 1'b1;
      repeat (5) begin
         step();
         checks++;
         if (obs_ready[1] !== 1'b0 || obs_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_hold got=ready%0b/en%0b exp=ready0/en0", obs_ready[1], obs_en);
         end
      end
      full_drv = 1'b0;
      run_until_drained(20, "bp");
      checks++;
      if (wr_data.size() != 4) begin
         failures++;
         $display("[TB] FAIL bp_count got=%0d exp=4", wr_data.size());
      end
      for (int k = 0; k < 4; k++) begin
         if (k < wr_data.size()) begin
            checks++;
            if (wr_data[k] !== 8'hB0 + 8'(k)) begin
               failures++;
               $display("[TB] FAIL bp_beat%0d got=%02h exp=%02h", k, wr_data[k], 8'hB0 + 8'(k));
            end
         end
      end
      if (wr_cyc.size() >= 3) begin
         checks++;
         if (wr_cyc[2] != wr_cyc[1] + 6) begin
            failures++;
            $display("[TB] FAIL bp_resume got=%0d exp=%0d", wr_cyc[2], wr_cyc[1] + 6);
         end
      end
   endtask

   task automatic test_early_last();
      int         exp_g [4];
      logic [7:0] exp_d [4];
      exp_g = '{3, 3, 0, 0};
      exp_d = '{8'hD0, 8'hD1, 8'hE0, 8'hE1};
      do_reset();
      push_msg(3, 2, 8'hD0, 1'b1);
      step();
      push_msg(0, 2, 8'hE0, 1'b1);
      run_until_drained(20, "early_last");
      checks++;
      if (wr_data.size() != 4) begin
         failures++;
         $display("[TB] FAIL early_last_count got=%0d exp=4", wr_data.size());
      end
      for (int k = 0; k < 4; k++) begin
         if (k < wr_data.size()) begin
            checks++;
            if (wr_gid[k] != exp_g[k] || wr_data[k] !== exp_d[k]) begin
               failures++;
               $display("[TB] FAIL early_last_beat%0d got=gid%0d/%02h exp=gid%0d/%02h",
                        k, wr_gid[k], wr_data[k], exp_g[k], exp_d[k]);
            end
         end
      end
      if (wr_cyc.size() >= 3) begin
         checks++;
         if (wr_cyc[2] != wr_cyc[1] + 2) begin
            failures++;
            $display("[TB] FAIL early_last_bubble got=%0d exp=%0d", wr_cyc[2], wr_cyc[1] + 2);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int n;
      do_reset();
      push_msg(2, 4, 8'hC0, 1'b1);
      n = 0;
      while (wr_data.size() < 1 && n < 10) begin
         step();
         n++;
      end
      push_msg(1, 2, 8'hF0, 1'b1);
      drive_inputs();
      w_rst_n = 1'b0;
      #1;
      checks += 3;
      if (fifo_w_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rst_mid_en got=%0b exp=0", fifo_w_en);
      end
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rst_mid_busy got=%0b exp=0", busy);
      end
      if (req_ready !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL rst_mid_ready got=%b exp=0000", req_ready);
      end
      @(posedge w_clk);
      #1;
      cyc++;
      w_rst_n = 1'b1;
      model_reset();
      clear_log();
      run_until_drained(40, "rst_mid");
      checks++;
      if (wr_data.size() != 5) begin
         failures++;
         $display("[TB] FAIL rst_mid_count got=%0d exp=5", wr_data.size());
      end
      if (wr_data.size() >= 3) begin
         checks += 2;
         if (wr_gid[0] != 1 || wr_data[0] !== 8'hF0) begin
            failures++;
            $display("[TB] FAIL rst_mid_first got=gid%0d/%02h exp=gid1/f0", wr_gid[0], wr_data[0]);
         end
         if (wr_gid[2] != 2 || wr_data[2] !== 8'hC1) begin
            failures++;
            $display("[TB] FAIL rst_mid_resume got=gid%0d/%02h exp=gid2/c1", wr_gid[2], wr_data[2]);
         end
      end
   endtask

`ifdef ARB_PKT_LOCK_EN
   task automatic test_pkt_lock();
      int n;
      bit gapped;
      do_reset();
      push_msg(0, 6, 8'h60, 1'b1);
      push_msg(1, 2, 8'h70, 1'b1);
      n      = 0;
      gapped = 1'b0;
      while ((!queues_empty() || m_owner >= 0) && n < 40) begin
         if (!gapped && wr_data.size() == 3) begin
            gap[0] = 2;
            gapped = 1'b1;
         end
         step();
         n++;
      end
      checks++;
      if (wr_data.size() != 8) begin
         failures++;
         $display("[TB] FAIL pkt_lock_count got=%0d exp=8", wr_data.size());
      end
      for (int k = 0; k < 8; k++) begin
         if (k < wr_data.size()) begin
            checks++;
            if (wr_gid[k] != (k < 6 ? 0 : 1) ||
                wr_data[k] !== (k < 6 ? 8'h60 + 8'(k) : 8'h70 + 8'(k - 6))) begin
               failures++;
               $display("[TB] FAIL pkt_lock_beat%0d got=gid%0d/%02h", k, wr_gid[k], wr_data[k]);
            end
         end
      end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         full_drv = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (q_data[i].size() < 8 && $urandom_range(0, 7) == 0) begin
               push_msg(i, int'($urandom_range(1, 6)), 8'($urandom), 1'b1);
            end
            if (gap[i] == 0 && $urandom_range(0, 15) == 0) begin
               gap[i] = int'($urandom_range(1, 2));
            end
         end
         step();
      end
      full_drv = 1'b0;
      run_until_drained(400, "random");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      w_rst_n  = 1'b0;
      full_drv = 1'b0;
      model_reset();
      test_reset();
      test_single();
`ifndef ARB_PKT_LOCK_EN
      test_round_robin();
`endif
      test_backpressure();
      test_early_last();
      test_reset_mid_burst();
`ifdef ARB_PKT_LOCK_EN
      test_pkt_lock();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
